regression_loader: RTL and testbench
====================================

REGRESSION_LOADER -- requirements
Module: regression_loader

Interface
REQ-001 Parameter DW, 20, width of x and y sample data.
REQ-002 Parameter AW, 8, sample address and count width.
REQ-003 Parameter N, 150, samples per job; legal range 1..2^AW.
REQ-004 Parameter TMO, 4096, watchdog limit in cycles; used only with REQ-035.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low; rst=0 sampled at a clk edge resets the block.
REQ-007 go  in  1  job request; sampled only in IDLE.
REQ-008 in_valid  in  1  sample pair valid.
REQ-009 in_x  in  DW  sample x.
REQ-010 in_y  in  DW  sample y.
REQ-011 in_ready  out  1  block accepts a sample this cycle.
REQ-012 mem_we  out  1  sample memory write strobe.
REQ-013 mem_addr  out  AW  sample memory write address.
REQ-014 mem_x, mem_y  out  DW each  sample memory write data.
REQ-015 dp_start  out  1  start pulse to regression datapath controller.
REQ-016 dp_ready  in  1  datapath controller idle flag; high when idle, low while computing.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle job-complete pulse.
REQ-019 timeout  out  1  sticky watchdog flag.

Function
REQ-020 States SHALL be IDLE, LOAD, FLUSH, START, WAIT_BUSY, WAIT_DONE, DONE.
REQ-021 IDLE: go=1 -> LOAD, clears sample counter and timeout; go=0 -> stay IDLE; go in any other state is ignored.
REQ-022 in_ready SHALL be 1 exactly in LOAD, combinationally from state, independent of in_valid.
REQ-023 Accept = in_valid & in_ready; each accept captures in_x/in_y and counter value, then increments counter.
REQ-024 Write latency 1: the cycle after an accept, mem_we=1, mem_addr=captured index, mem_x/mem_y=captured data; otherwise mem_we=0.
REQ-025 Counter SHALL never exceed N; accept with counter=N-1 -> FLUSH; no further accepts until next job.
REQ-026 in_valid=0 in LOAD SHALL stall indefinitely with no state change.
REQ-027 FLUSH lasts one cycle (last memory write) -> START.
REQ-028 START lasts one cycle with dp_start=1 -> WAIT_BUSY; dp_start=0 in every other state.
REQ-029 WAIT_BUSY: dp_ready=0 -> WAIT_DONE; else stay.
REQ-030 WAIT_DONE: dp_ready=1 -> DONE; else stay.
REQ-031 DONE lasts one cycle with done=1 -> IDLE.
REQ-032 Addresses SHALL be 0..N-1 in acceptance order, no wrap, no gaps.

Reset
REQ-033 On rst=0: state IDLE, counter 0, in_ready=0, mem_we=0, mem_addr=0, mem_x=0, mem_y=0, dp_start=0, busy=0, done=0, timeout=0.
REQ-034 Reset mid-job SHALL abort immediately, with no further mem_we or dp_start; dp_ready is ignored until the next go.

Configuration
REQ-035 Macro REGRESSION_LOADER_TIMEOUT_EN defined: cycle counter runs in WAIT_BUSY and WAIT_DONE, cleared on entering WAIT_BUSY. Reaching TMO sets timeout=1 and goes to IDLE without a done pulse. timeout holds until the next accepted go or reset.
REQ-036 Macro undefined: no watchdog logic; timeout tied 0; WAIT states wait indefinitely.

Verification (N=4 override)
REQ-037 Reset, go=1, 4 back-to-back valid pairs (1,2),(3,4),(5,6),(7,8) -> mem_we 4 cycles, addr 0..3 with matching data, each one cycle after accept; in_ready=0 after the 4th.
REQ-038 in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 writes, addresses contiguous 0..3, no write on idle cycles.
REQ-039 After FLUSH -> dp_start high exactly 1 cycle. Model drops dp_ready next cycle, raises it 20 cycles later -> done pulse 1 cycle after dp_ready rises, then busy=0.
REQ-040 go=1 while in WAIT_DONE -> ignored. rst=0 asserted mid-LOAD after 2 accepts -> all outputs at reset values next cycle; a new job then restarts at addr 0.
REQ-041 TIMEOUT_EN, TMO=16, dp_ready held 1 after dp_start -> timeout=1 after 16 cycles, state IDLE, done never pulses. Next go clears timeout.
REQ-042 Macro undefined, same stimulus -> timeout stays 0 and busy stays 1 for 1000 cycles.

Source files
------------

// File: rtl/regression_loader.sv
// Sample loader for the regression datapath: buffers N (x,y) pairs into sample memory,
// then handshakes with the datapath controller. Optional watchdog: REGRESSION_LOADER_TIMEOUT_EN.
module regression_loader #(
  parameter int DW  = 20,
  parameter int AW  = 8,
  parameter int N   = 150,
  parameter int TMO = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          in_valid,
  input  logic [DW-1:0] in_x,
  input  logic [DW-1:0] in_y,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_x,
  output logic [DW-1:0] mem_y,
  output logic          dp_start,
  input  logic          dp_ready,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_DONE
  } state_t;

  // One extra bit so N = 2^AW still fits in the sample counter.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(N - 1);

  state_t        r_state;
  logic [AW:0]   r_cnt;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_x;
  logic [DW-1:0] r_mem_y;
  logic          r_dp_start;
  logic          r_busy;
  logic          r_done;
  logic          w_acc;

`ifdef REGRESSION_LOADER_TIMEOUT_EN
  localparam int          TW       = $clog2(TMO + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign in_ready = (r_state == S_LOAD);
  assign w_acc    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_x    <= '0;
      r_mem_y    <= '0;
      r_dp_start <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef REGRESSION_LOADER_TIMEOUT_EN
      r_tmo_cnt  <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_mem_we   <= w_acc;
      r_dp_start <= 1'b0;
      r_done     <= 1'b0;
      if (w_acc) begin
        r_mem_addr <= r_cnt[AW-1:0];
        r_mem_x    <= in_x;
        r_mem_y    <= in_y;
        r_cnt      <= r_cnt + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef REGRESSION_LOADER_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (w_acc && (r_cnt == LAST_IDX)) r_state <= S_FLUSH;
        end
        // FLUSH is the cycle the final sample is written out.
        S_FLUSH: begin
          r_state    <= S_START;
          r_dp_start <= 1'b1;
        end
        S_START: begin
          r_state <= S_WAIT_BUSY;
`ifdef REGRESSION_LOADER_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        S_WAIT_BUSY: begin
`ifdef REGRESSION_LOADER_TIMEOUT_EN
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
          if (!dp_ready) begin
            r_state <= S_WAIT_DONE;
          end
`ifdef REGRESSION_LOADER_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end
`endif
        end
        S_WAIT_DONE: begin
`ifdef REGRESSION_LOADER_TIMEOUT_EN
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
          if (dp_ready) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
`ifdef REGRESSION_LOADER_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_x    = r_mem_x;
  assign mem_y    = r_mem_y;
  assign dp_start = r_dp_start;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_regression_loader.sv
// Scoreboard bench for regression_loader (N=4, TMO=16); expected writes are queued at issue
// time and checked by a negedge monitor running alongside the stimulus.
module tb_regression_loader;
  localparam int DW = 20, AW = 8, N = 4, TMO = 16;

  logic          clk = 1'b0, rst = 1'b0, go = 1'b0, in_valid = 1'b0, dp_ready = 1'b1;
  logic [DW-1:0] in_x = '0, in_y = '0;
  logic          in_ready, mem_we, dp_start, busy, done, timeout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_x, mem_y;

  regression_loader #(.DW(DW), .AW(AW), .N(N), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_x(mem_x), .mem_y(mem_y),
    .dp_start(dp_start), .dp_ready(dp_ready), .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    int            c;
  } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  bit loading = 0;
  int k = 0;
  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, 64'({in_ready, mem_we, mem_addr, mem_x, mem_y, dp_start, busy, done, timeout}), 64'd0);
  endtask

  task automatic start_job();
    in_valid = 1'b0;
    go = 1'b1;
    step();
    go = 1'b0;
    loading = 1;
    k = 0;
    chk("busy_after_go", 64'(busy), 64'd1);
  endtask

  // Offer samples until the model has accepted 'stop' of them (or the job is full).
  task automatic load(input int mode, input int stop);
    int i;
    logic v;
    logic [DW-1:0] x, y;
    i = 0;
    while (loading && k < stop) begin
      chk("in_ready_load", 64'(in_ready), 64'(loading));
      case (mode)
        0: v = 1'b1;
        1: v = pat[i % 7] != 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (mode == 0) begin
        x = DW'(2 * k + 1);
        y = DW'(2 * k + 2);
      end else begin
        x = DW'($urandom);
        y = DW'($urandom);
      end
      in_valid = v;
      in_x = x;
      in_y = y;
      if (v) begin
        q.push_back('{a: AW'(k), x: x, y: y, c: cyc + 1});
        k++;
        if (k == N) loading = 0;
      end
      i++;
      step();
      if (i > 200) begin
        chk("load_bound", 64'(i), 64'd0);
        loading = 0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_load();
    chk("in_ready_after_last", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_x = DW'($urandom);
    step();
    in_valid = 1'b0;
    chk("dp_start_pulse", 64'(dp_start), 64'd1);
  endtask

  task automatic dp_normal();
    int bad;
    dp_ready = 1'b0;
    step();
    chk("dp_start_single", 64'(dp_start), 64'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      go = (i == 5);
      step();
      if (!busy || done || in_ready || dp_start || timeout) bad++;
    end
    go = 1'b0;
    chk("wait_quiet_go_ignored", 64'(bad), 64'd0);
    dp_ready = 1'b1;
    step();
    chk("done_pulse", 64'({done, busy}), 64'b11);
    step();
    chk("done_clear_idle", 64'({done, busy, in_ready}), 64'b000);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (mem_we) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_write addr=%0d x=%0h y=%0h required=no write", mem_addr, mem_x, mem_y);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("mem_write", {mem_addr, mem_x, mem_y, 16'(cyc)}, {e.a, e.x, e.y, 16'(e.c)});
          end
        end
      end
      begin
        int bad, dn;
        repeat (2) step();
        check_reset_outputs("reset_outputs");
        rst = 1'b1;
        step();

        start_job(); load(0, N); finish_load(); dp_normal();
        start_job(); load(1, N); finish_load(); dp_normal();
        start_job(); load(2, N); finish_load(); dp_normal();

        start_job(); load(0, 2);
        rst = 1'b0;
        step();
        check_reset_outputs("midjob_reset_outputs");
        loading = 0;
        rst = 1'b1;
        step();
        chk("no_write_after_reset", 64'({mem_we, dp_start, busy}), 64'd0);
        start_job(); load(2, N); finish_load(); dp_normal();

        start_job(); load(2, N); finish_load();
        dp_ready = 1'b1;
        bad = 0;
        dn = 0;
`ifdef REGRESSION_LOADER_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) begin
          step();
          if (timeout || !busy) bad++;
          if (done) dn++;
        end
        chk("timeout_not_early", 64'(bad), 64'd0);
        step();
        if (done) dn++;
        chk("timeout_set_idle", 64'({timeout, busy}), 64'b10);
        repeat (3) begin
          step();
          if (done) dn++;
        end
        chk("timeout_sticky_no_done", 64'({timeout, 8'(dn)}), {1'b1, 8'd0});
        start_job();
        chk("go_clears_timeout", 64'({timeout, in_ready}), 64'b01);
        load(2, N); finish_load(); dp_normal();
`else
        for (int i = 0; i < 1000; i++) begin
          step();
          if (timeout || !busy) bad++;
          if (done) dn++;
        end
        chk("hang_without_watchdog", 64'({16'(bad), 16'(dn)}), 64'd0);
        rst = 1'b0;
        step();
        check_reset_outputs("reset_from_wait");
        rst = 1'b1;
`endif
        repeat (3) step();
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join_any
  end

endmodule
